// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage RV32 pipeline: forwarding, stalls, flushes.
// Build option: define HAZARD_FWD_EN for forwarding; otherwise stall on RAW.
module hazard_unit #(
    parameter int         XLEN_REGS = 5,
    parameter logic [2:0] LOAD_SRC  = 3'b001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN_REGS-1:0] Rs1D,
    input  logic [XLEN_REGS-1:0] Rs2D,
    input  logic [XLEN_REGS-1:0] RdD,
    input  logic                 RegWriteD,
    input  logic [2:0]           ResultSrcD,
    input  logic                 PCSrcE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE
);

    logic [XLEN_REGS-1:0] Rs1E;
    logic [XLEN_REGS-1:0] Rs2E;
    logic [XLEN_REGS-1:0] RdE;
    logic                 RegWriteE;
    logic                 LoadE;
    logic [XLEN_REGS-1:0] RdM;
    logic                 RegWriteM;
    logic [XLEN_REGS-1:0] RdW;
    logic                 RegWriteW;

    logic                 stall;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;

    // E shadow: capture Decode fields, or a bubble when E is flushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Rs1E      <= '0;
            Rs2E      <= '0;
            RdE       <= '0;
            RegWriteE <= 1'b0;
            LoadE     <= 1'b0;
        end else if (FlushE) begin
            Rs1E      <= '0;
            Rs2E      <= '0;
            RdE       <= '0;
            RegWriteE <= 1'b0;
            LoadE     <= 1'b0;
        end else begin
            Rs1E      <= Rs1D;
            Rs2E      <= Rs2D;
            RdE       <= RdD;
            RegWriteE <= RegWriteD;
            LoadE     <= (ResultSrcD == LOAD_SRC);
        end
    end

    // M and W shadows advance every cycle; they never stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RdM       <= '0;
            RegWriteM <= 1'b0;
            RdW       <= '0;
            RegWriteW <= 1'b0;
        end else begin
            RdM       <= RdE;
            RegWriteM <= RegWriteE;
            RdW       <= RdM;
            RegWriteW <= RegWriteM;
        end
    end

`ifdef HAZARD_FWD_EN
    // Only a load in E forces a stall; everything else is forwarded.
    always_comb begin
        stall = LoadE && (RdE != '0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Operand A select: M result has priority over W result.
    always_comb begin
        fwd_a = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
            fwd_a = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
            fwd_a = 2'b01;
    end

    // Operand B select, same priority as operand A.
    always_comb begin
        fwd_b = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
            fwd_b = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
            fwd_b = 2'b01;
    end
`else
    logic unused_shadow;
    assign unused_shadow = ^{Rs1E, Rs2E, LoadE, RdW, RegWriteW};

    // No bypass: hold Decode until writers in E and M are past M.
    // W is safe because the register file writes on the falling edge.
    always_comb begin
        stall = (RegWriteE && (RdE != '0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D))) ||
                (RegWriteM && (RdM != '0) &&
                 ((RdM == Rs1D) || (RdM == Rs2D)));
        fwd_a = 2'b00;
        fwd_b = 2'b00;
    end
`endif

    assign StallF    = reset & stall;
    assign StallD    = reset & stall;
    assign FlushD    = reset & PCSrcE;
    assign FlushE    = reset & (stall | PCSrcE);
    assign ForwardAE = {2{reset}} & fwd_a;
    assign ForwardBE = {2{reset}} & fwd_b;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; expectations follow HAZARD_FWD_EN.
module tb_hazard_unit;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] RdD;
    logic       RegWriteD;
    logic [2:0] ResultSrcD;
    logic       PCSrcE;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;

    int compared   = 0;
    int mismatched = 0;

    hazard_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .PCSrcE     (PCSrcE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic sf, input logic sd,
                       input logic fd, input logic fe,
                       input logic [1:0] fa, input logic [1:0] fb);
        cmp({tag, "_StallF"}, {1'b0, StallF}, {1'b0, sf});
        cmp({tag, "_StallD"}, {1'b0, StallD}, {1'b0, sd});
        cmp({tag, "_FlushD"}, {1'b0, FlushD}, {1'b0, fd});
        cmp({tag, "_FlushE"}, {1'b0, FlushE}, {1'b0, fe});
        cmp({tag, "_FwdA"}, ForwardAE, fa);
        cmp({tag, "_FwdB"}, ForwardBE, fb);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw,
                         input logic ld, input logic pc);
        Rs1D       = rs1;
        Rs2D       = rs2;
        RdD        = rd;
        RegWriteD  = rw;
        ResultSrcD = ld ? 3'b001 : 3'b000;
        PCSrcE     = pc;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(5, 5, 0, 0, 0, 1);
        chk("rst_hold", 0, 0, 0, 0, 2'b00, 2'b00);
        tick();
        drive(5, 5, 0, 0, 0, 1);
        chk("rst_edge", 0, 0, 0, 0, 2'b00, 2'b00);
        reset = 1'b1;
        #1;
        chk("rst_rel_pc", 0, 0, 1, 1, 2'b00, 2'b00);
        nops(3);

        // add x5,x1,x2 ; sub x6,x5,x3
        tick(); drive(1, 2, 5, 1, 0, 0);
        chk("t1_add", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(5, 3, 6, 1, 0, 0);
`ifdef HAZARD_FWD_EN
        chk("t1_sub", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t1_fwd", 0, 0, 0, 0, 2'b10, 2'b00);
`else
        chk("t1_st1", 1, 1, 0, 1, 2'b00, 2'b00);
        tick(); drive(5, 3, 6, 1, 0, 0);
        chk("t1_st2", 1, 1, 0, 1, 2'b00, 2'b00);
        tick(); drive(5, 3, 6, 1, 0, 0);
        chk("t1_go", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t1_fwd", 0, 0, 0, 0, 2'b00, 2'b00);
`endif
        nops(3);

        // lw x7 ; nop ; add x8,x7,x7
        tick(); drive(1, 0, 7, 1, 1, 0);
        chk("t2_lw", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t2_nop", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(7, 7, 8, 1, 0, 0);
`ifdef HAZARD_FWD_EN
        chk("t2_add", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t2_fwd", 0, 0, 0, 0, 2'b01, 2'b01);
`else
        chk("t2_st", 1, 1, 0, 1, 2'b00, 2'b00);
        tick(); drive(7, 7, 8, 1, 0, 0);
        chk("t2_go", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t2_fwd", 0, 0, 0, 0, 2'b00, 2'b00);
`endif
        nops(3);

        // lw x7 ; add x8,x7,x0
        tick(); drive(1, 0, 7, 1, 1, 0);
        chk("t3_lw", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(7, 0, 8, 1, 0, 0);
        chk("t3_st1", 1, 1, 0, 1, 2'b00, 2'b00);
        tick(); drive(7, 0, 8, 1, 0, 0);
`ifdef HAZARD_FWD_EN
        chk("t3_go", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t3_fwd", 0, 0, 0, 0, 2'b01, 2'b00);
`else
        chk("t3_st2", 1, 1, 0, 1, 2'b00, 2'b00);
        tick(); drive(7, 0, 8, 1, 0, 0);
        chk("t3_go", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t3_fwd", 0, 0, 0, 0, 2'b00, 2'b00);
`endif
        nops(3);

        // x0 writers: addi x0 ; add x9,x0,x0 ; lw x0 ; add x9,x0,x0
        tick(); drive(0, 0, 0, 1, 0, 0);
        chk("t4_addi", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 9, 1, 0, 0);
        chk("t4_use", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t4_fwdM", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(1, 0, 0, 1, 1, 0);
        chk("t4_lw", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 9, 1, 0, 0);
        chk("t4_lduse", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t4_ldfwdM", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t4_ldfwdW", 0, 0, 0, 0, 2'b00, 2'b00);
        nops(3);

        // lw x7 ; add x8,x7,x0 while a branch resolves taken
        tick(); drive(1, 0, 7, 1, 1, 0);
        chk("t5_lw", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(7, 0, 8, 1, 0, 1);
        chk("t5_both", 1, 1, 1, 1, 2'b00, 2'b00);
        tick(); drive(8, 8, 9, 1, 0, 0);
        chk("t5_bub", 0, 0, 0, 0, 2'b00, 2'b00);
        cmp("t5_RegWriteE", {1'b0, dut.RegWriteE}, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t5_nofwd", 0, 0, 0, 0, 2'b00, 2'b00);
        nops(3);

        // reset while M/W hold writers of Rs1E and a branch is taken
        tick(); drive(1, 2, 5, 1, 0, 0);
        chk("t6_a1", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(1, 2, 5, 1, 0, 0);
        chk("t6_a2", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(5, 5, 6, 1, 0, 0);
`ifdef HAZARD_FWD_EN
        chk("t6_sub", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 1);
        chk("t6_pre", 0, 0, 1, 1, 2'b10, 2'b10);
`else
        chk("t6_sub", 1, 1, 0, 1, 2'b00, 2'b00);
        tick(); drive(5, 5, 6, 1, 0, 1);
        chk("t6_pre", 1, 1, 1, 1, 2'b00, 2'b00);
`endif
        reset = 1'b0;
        #1;
        chk("t6_rst", 0, 0, 0, 0, 2'b00, 2'b00);
        tick();
        chk("t6_rst_edge", 0, 0, 0, 0, 2'b00, 2'b00);
        reset = 1'b1;
        drive(5, 5, 6, 1, 0, 0);
        chk("t6_rel", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t6_post", 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); drive(0, 0, 0, 0, 0, 0);
        chk("t6_post2", 0, 0, 0, 0, 2'b00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard resolution block for the five-stage pipelined RV32 core. It consumes the decode-stage register fields and the control that `controller` produces, and keeps its own E/M/W shadow pipeline of destination registers and write enables. From that state it generates operand forwarding selects, load-use stalls and branch/jump flushes. It drives `FlushE` back into `controller` and the stall/flush/forward controls into the datapath.

## Interface
Parameters:
- `XLEN_REGS`, 5: register-index width (32 architectural registers).
- `LOAD_SRC`, 3'b001: `ResultSrc` encoding that identifies a load.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Rs1D`  in  5  source register 1 of the instruction in Decode.
- `Rs2D`  in  5  source register 2 of the instruction in Decode.
- `RdD`  in  5  destination register of the instruction in Decode.
- `RegWriteD`  in  1  Decode instruction writes the register file.
- `ResultSrcD`  in  3  Decode result-source select; equal to `LOAD_SRC` means load.
- `PCSrcE`  in  1  taken branch/jump resolved in Execute.
- `StallF`  out  1  hold PC.
- `StallD`  out  1  hold the F/D pipeline register.
- `FlushD`  out  1  clear the F/D pipeline register.
- `FlushE`  out  1  clear the D/E pipeline registers (datapath and `controller`).
- `ForwardAE`  out  2  ALU operand A select: 00 register file, 01 W result, 10 M ALU result.
- `ForwardBE`  out  2  ALU operand B select, same encoding.

## Operation
- Shadow state:
  - E stage: `Rs1E`, `Rs2E`, `RdE`, `RegWriteE`, `LoadE`.
  - M stage: `RdM`, `RegWriteM`.
  - W stage: `RdW`, `RegWriteW`.
- E update each cycle:
  - `FlushE`=1: load a bubble (all E fields 0).
  - Otherwise: capture the D inputs, with `LoadE` = (`ResultSrcD`==`LOAD_SRC`).
- M and W update each cycle unconditionally: M<=E, W<=M. Neither stage is ever stalled.
- Load-use detection: `lwStall` = `LoadE` & `RdE`!=0 & (`RdE`==`Rs1D` | `RdE`==`Rs2D`).
- Output equations:
  - `StallF` = `StallD` = `lwStall`.
  - `FlushD` = `PCSrcE`.
  - `FlushE` = `lwStall` | `PCSrcE`.
- ForwardAE:
  - 10 if `RegWriteM` & `RdM`!=0 & `RdM`==`Rs1E`.
  - Otherwise 01 if `RegWriteW` & `RdW`!=0 & `RdW`==`Rs1E`.
  - Otherwise 00.
  - ForwardBE is identical, using `Rs2E`.
- x0 is never forwarded and never stalls.
- A load-use stall and `PCSrcE` in the same cycle: the flush wins in effect. D and E are both cleared, and the stall holds F on the wrong-path PC for one cycle. This is harmless and required; the bench checks it.

## Timing
- All outputs are combinational from the shadow state and the current D/E inputs, valid in the same cycle.
- Shadow registers have 1-cycle latency per stage.
- A load-use hazard produces exactly one stall cycle. The next cycle, `LoadE`=0 (bubble) and the dependency resolves through `ForwardAE`/`ForwardBE`=01.
- Reset asserted (`reset`=0):
  - All shadow registers are 0.
  - All outputs are forced to 0, regardless of `PCSrcE`.
- Reset release is synchronous to the next `clk` rising edge; the first post-reset capture happens on that edge.
- Reset mid-operation discards all in-flight shadow state immediately.

## Configuration
- `HAZARD_FWD_EN` defined:
  - Forwarding is active as described above.
  - Stalls occur only on load-use.
- `HAZARD_FWD_EN` undefined:
  - `ForwardAE`/`ForwardBE` are tied to 00.
  - Stall condition becomes any RAW hazard against E or M: (`RegWriteE` & `RdE`!=0 & `RdE` matches `Rs1D`/`Rs2D`) | (`RegWriteM` & `RdM`!=0 & `RdM` matches).
  - The register file writes on the falling edge, so W is not checked.
  - A dependent instruction stalls up to 2 cycles.
  - `FlushE` = stall | `PCSrcE`.

## Test plan
- `add x5,x1,x2` then `sub x6,x5,x3` -> cycle 2 of sub in E: `ForwardAE`=10, no stall. With the macro off: `StallD`=1 for 2 cycles, `ForwardAE`=00.
- `lw x7,0(x1)`, a nop, then `add x8,x7,x7` -> add in E: `ForwardAE`=`ForwardBE`=01, no stall.
- `lw x7,0(x1)` then `add x8,x7,x0` -> `StallF`=`StallD`=`FlushE`=1 for exactly 1 cycle, then `ForwardAE`=01.
- Writes to x0 (`addi x0,x0,5` then `add x9,x0,x0`, and a load to x0 followed by a use) -> forward selects 00, `lwStall` 0.
- `PCSrcE`=1 coinciding with a load-use hazard in D -> `FlushD`=`FlushE`=1 and `StallF`=1 in the same cycle; the next cycle E holds a bubble (`RegWriteE`=0).
- Assert `reset`=0 mid-stream with M/W matching `Rs1E` and `PCSrcE`=1 -> all outputs 0 immediately. After release, the first forward is 00 until new writers reach M.
